// File: rtl/servo_pkg.sv
// Shared types, defaults and the per-channel slew helper for the servo motion sequencer.
package servo_pkg;

   typedef logic [7:0] angle_t;

   typedef enum logic [2:0] {
      INIT      = 3'd0,
      IDLE      = 3'd1,
      MOVE      = 3'd2,
      STEP_CALC = 3'd3,
      LOAD      = 3'd4
   } seq_state_t;

   localparam int     SERVO_CHANNELS    = 4;
   localparam angle_t DEFAULT_CENTER    = 8'd90;
   localparam angle_t DEFAULT_MAX_ANGLE = 8'd180;

   // Move cur toward tgt by at most step; the 9-bit signed difference keeps 0..255 from wrapping.
   function automatic angle_t slew_step(input angle_t cur, input angle_t tgt, input angle_t step);
      logic signed [8:0] diff_s;
      logic signed [8:0] step_s;
      diff_s = $signed({1'b0, tgt}) - $signed({1'b0, cur});
      step_s = $signed({1'b0, step});
      if (diff_s > step_s) begin
         slew_step = cur + step;
      end else if (diff_s < -step_s) begin
         slew_step = cur - step;
      end else begin
         slew_step = tgt;
      end
   endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running servo frame counter; frame_tick is high on the last cycle of every frame.
module servo_frame_timer #(
   parameter int FRAME_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   output logic frame_tick
);

   localparam int            CW         = $clog2(FRAME_CYCLES);
   localparam logic [CW-1:0] LAST_COUNT = CW'(FRAME_CYCLES - 1);
   localparam logic [CW-1:0] PRE_COUNT  = CW'(FRAME_CYCLES - 2);

   logic [CW-1:0] count_r;
   logic          tick_r;

   // Count 0..FRAME_CYCLES-1; the tick is registered one count early so it lines up with LAST_COUNT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {CW{1'b0}};
         tick_r  <= 1'b0;
      end else begin
         if (count_r == LAST_COUNT) begin
            count_r <= {CW{1'b0}};
         end else begin
            count_r <= count_r + CW'(1);
         end
         tick_r <= (count_r == PRE_COUNT);
      end
   end

   assign frame_tick = tick_r;

endmodule

// File: rtl/servo_motion_sequencer.sv
// Slews four servo angles toward commanded targets once per frame and strobes the PWM block.
// Optional feature: define SERVO_IDLE_REFRESH_EN to re-issue nextangle every frame while idle.
module servo_motion_sequencer
   import servo_pkg::*;
#(
   parameter int         FRAME_CYCLES = 1000000,
   parameter logic [7:0] STEP         = 8'd2,
   parameter logic [7:0] CENTER       = DEFAULT_CENTER,
   parameter logic [7:0] MAX_ANGLE    = DEFAULT_MAX_ANGLE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_target,
   output logic [7:0]  angle1,
   output logic [7:0]  angle2,
   output logic [7:0]  angle3,
   output logic [7:0]  angle4,
   output logic        nextangle,
   output logic        busy,
   output logic        frame_tick
);

   angle_t [SERVO_CHANNELS-1:0] cur_r;
   angle_t [SERVO_CHANNELS-1:0] tgt_r;
   angle_t [SERVO_CHANNELS-1:0] cur_next_s;
   angle_t [SERVO_CHANNELS-1:0] tgt_next_s;
   seq_state_t                  state_r;
   logic                        frame_tick_s;
   logic                        accept_s;
   logic                        diff_s;
   logic                        nextangle_r;
   logic                        cmd_ready_r;
   logic                        busy_r;

   servo_frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick_s)
   );

   // Next targets (clamped on accept), next angles (slewed in STEP_CALC) and whether any channel still differs.
   always_comb begin
      accept_s   = cmd_valid & cmd_ready_r;
      tgt_next_s = tgt_r;
      cur_next_s = cur_r;
      diff_s     = 1'b0;
      for (int ch = 0; ch < SERVO_CHANNELS; ch++) begin
         if (accept_s) begin
            if (cmd_target[ch*8 +: 8] > MAX_ANGLE) begin
               tgt_next_s[ch] = MAX_ANGLE;
            end else begin
               tgt_next_s[ch] = cmd_target[ch*8 +: 8];
            end
         end else begin
            tgt_next_s[ch] = tgt_r[ch];
         end
         if (state_r == STEP_CALC) begin
            cur_next_s[ch] = slew_step(cur_r[ch], tgt_r[ch], STEP);
         end else begin
            cur_next_s[ch] = cur_r[ch];
         end
         diff_s = diff_s | (cur_next_s[ch] != tgt_next_s[ch]);
      end
   end

   // Sequencer FSM; ready and strobe are registered together with the state they belong to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= INIT;
         cur_r       <= {SERVO_CHANNELS{CENTER}};
         tgt_r       <= {SERVO_CHANNELS{CENTER}};
         nextangle_r <= 1'b0;
         cmd_ready_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         cur_r       <= cur_next_s;
         tgt_r       <= tgt_next_s;
         busy_r      <= diff_s;
         nextangle_r <= 1'b0;
         cmd_ready_r <= 1'b0;
         case (state_r)
            INIT: begin
               if (frame_tick_s) begin
                  state_r     <= LOAD;
                  nextangle_r <= 1'b1;
               end else begin
                  state_r <= INIT;
               end
            end
            IDLE: begin
`ifdef SERVO_IDLE_REFRESH_EN
               if (frame_tick_s && diff_s) begin
                  state_r <= STEP_CALC;
               end else if (frame_tick_s) begin
                  state_r     <= LOAD;
                  nextangle_r <= 1'b1;
               end else if (diff_s) begin
                  state_r     <= MOVE;
                  cmd_ready_r <= 1'b1;
               end else begin
                  state_r     <= IDLE;
                  cmd_ready_r <= 1'b1;
               end
`else
               if (diff_s) begin
                  state_r     <= MOVE;
                  cmd_ready_r <= 1'b1;
               end else begin
                  state_r     <= IDLE;
                  cmd_ready_r <= 1'b1;
               end
`endif
            end
            MOVE: begin
               // A retarget that lands exactly on the current angles ends the move without a strobe.
               if (!diff_s) begin
                  state_r     <= IDLE;
                  cmd_ready_r <= 1'b1;
               end else if (frame_tick_s) begin
                  state_r <= STEP_CALC;
               end else begin
                  state_r     <= MOVE;
                  cmd_ready_r <= 1'b1;
               end
            end
            STEP_CALC: begin
               state_r     <= LOAD;
               nextangle_r <= 1'b1;
            end
            LOAD: begin
               if (busy_r) begin
                  state_r <= MOVE;
               end else begin
                  state_r <= IDLE;
               end
               cmd_ready_r <= 1'b1;
            end
            default: begin
               state_r <= INIT;
            end
         endcase
      end
   end

   assign angle1     = cur_r[0];
   assign angle2     = cur_r[1];
   assign angle3     = cur_r[2];
   assign angle4     = cur_r[3];
   assign nextangle  = nextangle_r;
   assign cmd_ready  = cmd_ready_r;
   assign busy       = busy_r;
   assign frame_tick = frame_tick_s;

endmodule
